// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NREQ requesters.
// Optional macro RF_WARB_DROP_R0_EN: grant writes to $0 but never issue them.
module rf_write_arbiter #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [4:0]           rf_a3,
    output logic [31:0]          rf_wd3,
    output logic [CNT_W-1:0]     cont_cnt
);
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] r_ptr;
    logic             r_we;
    logic [4:0]       r_a3;
    logic [31:0]      r_wd3;
    logic [CNT_W-1:0] r_cnt;

    logic [4:0]       w_addr [NREQ];
    logic [31:0]      w_data [NREQ];
    logic [NREQ-1:0]  w_grant;
    logic [PTR_W-1:0] w_gidx;
    logic             w_hs;
    logic [PTR_W:0]   w_scan;
    logic [2:0]       w_pop;
    logic             w_cont;
    logic             w_issue;
    logic [PTR_W-1:0] w_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr[gi] = req_addr[gi*5 +: 5];
            assign w_data[gi] = req_data[gi*32 +: 32];
        end
    endgenerate

    // First valid index at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_hs    = 1'b0;
        w_scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_scan >= (PTR_W+1)'(NREQ))
                w_scan = w_scan - (PTR_W+1)'(NREQ);
            if (!w_hs && !hold && rst_n && req_valid[w_scan[PTR_W-1:0]]) begin
                w_hs   = 1'b1;
                w_gidx = w_scan[PTR_W-1:0];
            end
        end
        if (w_hs)
            w_grant[w_gidx] = 1'b1;
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NREQ; k++)
            w_pop = w_pop + {2'b00, req_valid[k]};
    end

    assign w_cont     = !hold && (w_pop >= 3'd2);
    assign w_ptr_next = (w_gidx == PTR_W'(NREQ-1)) ? '0 : w_gidx + PTR_W'(1);

`ifdef RF_WARB_DROP_R0_EN
    assign w_issue = w_hs && (w_addr[w_gidx] != 5'd0);
`else
    assign w_issue = w_hs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_we  <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
            r_cnt <= '0;
        end else begin
            if (w_hs)
                r_ptr <= w_ptr_next;
            r_we <= w_issue;
            if (w_issue) begin
                r_a3  <= w_addr[w_gidx];
                r_wd3 <= w_data[w_gidx];
            end
            if (w_cont && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign req_ready = w_grant;
    assign rf_we     = r_we;
    assign rf_a3     = r_a3;
    assign rf_wd3    = r_wd3;
    assign cont_cnt  = r_cnt;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed table, corner sequences, random vs model.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [15:0] cont_cnt;
    logic [1:0]  s_ready;
    logic        s_we;
    logic [4:0]  s_a3;
    logic [31:0] s_wd3;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.NREQ(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .cont_cnt(cont_cnt));

    rf_write_arbiter #(.NREQ(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(s_ready),
        .rf_we(s_we), .rf_a3(s_a3), .rf_wd3(s_wd3), .cont_cnt(s_cnt));

    // Register file fed by the arbiter outputs; $0 stays zero.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else if (rf_we && rf_a3 != 5'd0) begin
            rf_mem[rf_a3] <= rf_wd3;
        end
    end

    // Reference model state
    int          m_ptr, m_cnt, m_cnt2, m_g;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_cnt2 = 0; m_g = -1;
        m_we = 1'b0; m_a3 = 5'd0; m_wd3 = 32'd0;
    endtask

    function automatic int model_grant();
        if (hold) return -1;
        for (int k = 0; k < 2; k++)
            if (req_valid[(m_ptr + k) % 2]) return (m_ptr + k) % 2;
        return -1;
    endfunction

    task automatic model_check();
        logic [1:0] exp_ready;
        m_g = model_grant();
        exp_ready = (m_g >= 0) ? 2'(1 << m_g) : 2'b00;
        chk("ready", req_ready, exp_ready);
        chk("sat_ready", s_ready, exp_ready);
        chk("we", rf_we, m_we);
        chk("a3", rf_a3, m_a3);
        chk("wd3", rf_wd3, m_wd3);
        chk("cnt", cont_cnt, m_cnt);
        chk("sat_cnt", s_cnt, m_cnt2);
    endtask

    task automatic model_update();
        logic [4:0]  a;
        logic [31:0] d;
        if (!hold && $countones(req_valid) >= 2) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
        end
        if (m_g >= 0) begin
            a = req_addr[m_g*5 +: 5];
            d = req_data[m_g*32 +: 32];
            m_ptr = (m_g + 1) % 2;
`ifdef RF_WARB_DROP_R0_EN
            if (a == 5'd0) begin
                m_we = 1'b0;
            end else begin
                m_we = 1'b1; m_a3 = a; m_wd3 = d;
            end
`else
            m_we = 1'b1; m_a3 = a; m_wd3 = d;
`endif
            $display("handshake g=%0d addr=%0d data=%h t=%0t", m_g, a, d, $time);
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic tick_rest();
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        tick_rest();
    endtask

    typedef struct {
        logic       hold;
        logic [1:0] valid;
        logic [1:0] ready;
        logic       we;
        logic [4:0] a3;
        int         cnt;
    } vec_t;
    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 2'b11, 2'b01, 1'b0, 5'd0, 0};
        tbl[1]  = '{1'b0, 2'b11, 2'b10, 1'b1, 5'd1, 1};
        tbl[2]  = '{1'b0, 2'b11, 2'b01, 1'b1, 5'd2, 2};
        tbl[3]  = '{1'b0, 2'b11, 2'b10, 1'b1, 5'd1, 3};
        tbl[4]  = '{1'b1, 2'b11, 2'b00, 1'b1, 5'd2, 4};
        tbl[5]  = '{1'b1, 2'b11, 2'b00, 1'b0, 5'd2, 4};
        tbl[6]  = '{1'b0, 2'b11, 2'b01, 1'b0, 5'd2, 4};
        tbl[7]  = '{1'b0, 2'b00, 2'b00, 1'b1, 5'd1, 5};
        tbl[8]  = '{1'b0, 2'b10, 2'b10, 1'b0, 5'd1, 5};
        tbl[9]  = '{1'b0, 2'b10, 2'b10, 1'b1, 5'd2, 5};
        tbl[10] = '{1'b0, 2'b01, 2'b01, 1'b1, 5'd2, 5};
        tbl[11] = '{1'b0, 2'b00, 2'b00, 1'b1, 5'd1, 5};

        // Reset with both requesters valid
        rst_n = 1'b0; hold = 1'b0; req_valid = 2'b11;
        req_addr = {5'd2, 5'd1}; req_data = {32'd2, 32'd1};
        #12;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_a3", rf_a3, 5'd0);
        chk("rst_wd3", rf_wd3, 32'd0);
        chk("rst_cnt", cont_cnt, 16'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // Fairness, hold, single-requester back-to-back
        for (int r = 0; r < 12; r++) begin
            hold = tbl[r].hold;
            req_valid = tbl[r].valid;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].ready);
            chk($sformatf("tbl%0d_we", r), rf_we, tbl[r].we);
            chk($sformatf("tbl%0d_a3", r), rf_a3, tbl[r].a3);
            chk($sformatf("tbl%0d_cnt", r), cont_cnt, tbl[r].cnt);
            chk($sformatf("tbl%0d_satcnt", r), s_cnt, (tbl[r].cnt > 3) ? 3 : tbl[r].cnt);
            tick_rest();
        end

        // Single requester 1 writing DEADBEEF to r5 for 3 cycles
        hold = 1'b0; req_valid = 2'b10;
        req_addr = {5'd5, 5'd1}; req_data = {32'hDEADBEEF, 32'd1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_ready", req_ready, 2'b10);
            tick_rest();
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_we", rf_we, 1'b1);
        chk("single_a3", rf_a3, 5'd5);
        chk("single_wd3", rf_wd3, 32'hDEADBEEF);
        tick_rest();
        @(negedge clk);
        chk("single_reg5", rf_mem[5], 32'hDEADBEEF);
        tick_rest();

        // Write to $0 from requester 0
        req_valid = 2'b01;
        req_addr = {5'd5, 5'd0}; req_data = {32'hDEADBEEF, 32'h1234};
        @(negedge clk);
        chk("r0_ready", req_ready, 2'b01);
        tick_rest();
        req_valid = 2'b11;
        @(negedge clk);
        chk("r0_ptr_adv", req_ready, 2'b10);
`ifdef RF_WARB_DROP_R0_EN
        chk("r0_we", rf_we, 1'b0);
        chk("r0_a3", rf_a3, 5'd5);
`else
        chk("r0_we", rf_we, 1'b1);
        chk("r0_a3", rf_a3, 5'd0);
        chk("r0_wd3", rf_wd3, 32'h1234);
`endif
        tick_rest();
        req_valid = 2'b00;
        cyc();

        // Reset in the middle of a registered write
        req_valid = 2'b01; req_addr = {5'd5, 5'd7};
        cyc();
        #2;
        chk("mid_we_before", rf_we, 1'b1);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("mid_we", rf_we, 1'b0);
        chk("mid_ready", req_ready, 2'b00);
        chk("mid_a3", rf_a3, 5'd0);
        chk("mid_cnt", cont_cnt, 16'd0);
        #10;
        req_valid = 2'b00;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // Randomized traffic, requesters keep payload until granted
        for (int n = 0; n < 400; n++) begin
            logic [1:0] nv;
            hold = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || m_g == i) begin
                    req_addr[i*5 +: 5]   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    req_data[i*32 +: 32] = $urandom;
                end
                nv[i] = ($urandom_range(0, 3) != 0);
            end
            req_valid = nv;
            cyc();
        end
        req_valid = 2'b00;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
